// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor: FSM state encoding and synchronizer depth.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAILED    = 3'd4
  } state_t;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit flop synchronizer with asynchronous active-low clear.
module sync_bit #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < N; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[N-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock, releases fabric reset,
// retries on lock timeout and latches failure after too many consecutive timeouts.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// RESET_PLL | pll_rst held high for RST_PULSE_CYCLES
// WAIT_LOCK | pll_rst low, waiting for synchronized lock or timeout
// STABLE    | lock seen, counting LOCK_STABLE_CYCLES consecutive locked cycles
// RUN       | lock qualified, fabric reset released, ready high
// FAILED    | retries exhausted, PLL held in reset until rst_n
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int MAX_RETRIES         = 7,
  parameter int RETRY_W             = 3,
  parameter int CNT_W               = 20
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count,
  output logic               fail
);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lk;

  sync_bit #(.N(SYNC_DEPTH)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lk)
  );

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
      fail        <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          // Lock seen on the timeout cycle takes priority over a retry.
          if (lk) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_count == RETRY_MAX) begin
              state <= FAILED;
              fail  <= 1'b1;
            end else begin
              state       <= RESET_PLL;
              retry_count <= retry_count + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABLE: begin
          if (!lk) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state       <= RUN;
            sys_rst     <= 1'b0;
            ready       <= 1'b1;
            retry_count <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lk) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            lock_lost <= 1'b1;
          end
        end
        FAILED: begin
          pll_rst <= 1'b1;
          sys_rst <= 1'b1;
          ready   <= 1'b0;
          fail    <= 1'b1;
        end
        default: begin
          state   <= RESET_PLL;
          cnt     <= '0;
          pll_rst <= 1'b1;
          sys_rst <= 1'b1;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: an event-level model predicts every output change.
module tb_pll_lock_supervisor;

  localparam int RST = 4;
  localparam int ST  = 8;
  localparam int TO  = 32;
  localparam int MAXR = 2;
  localparam int MAXN = 700;

  logic       refclk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_rst, ready, lock_lost, fail;
  logic [2:0] retry_count;

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES(RST), .LOCK_STABLE_CYCLES(ST), .LOCK_TIMEOUT_CYCLES(TO),
    .MAX_RETRIES(MAXR), .RETRY_W(3), .CNT_W(20)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .sys_rst(sys_rst), .ready(ready), .lock_lost(lock_lost),
    .retry_count(retry_count), .fail(fail)
  );

  always #5 refclk = ~refclk;

  typedef struct { int cyc; logic [7:0] v; } ev_t;
  ev_t        exp_q[$];
  bit         L[0:MAXN+3];
  int         compared = 0;
  int         mismatched = 0;
  bit         mon_en = 0;
  int         mon_cyc = 0;
  logic [7:0] prev_v;
  logic [7:0] last_exp;

  function automatic logic [7:0] pack(bit pr, bit sr, bit rd, bit ll, bit fl, int rc);
    return {pr, sr, rd, ll, fl, 3'(rc)};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {pll_rst, sys_rst, ready, lock_lost, fail, retry_count};
  endfunction

  // Synchronized lock as seen by the decision at edge e (two-flop delay).
  function automatic bit lkv(int e);
    if (e < 3 || e - 2 > MAXN + 3) return 1'b0;
    return L[e-2];
  endfunction

  function automatic void push(int c, logic [7:0] v, int n);
    if (c <= n) begin
      exp_q.push_back('{c, v});
      last_exp = v;
    end
  endfunction

  // Walks the lock timeline phase by phase and records each expected output change.
  function automatic void build_model(int n);
    int e, w, f, j, g, run_at, retries;
    bit timed_out;
    exp_q.delete();
    last_exp = pack(1, 1, 0, 0, 0, 0);
    e = 0;
    retries = 0;
    while (1) begin
      e += RST;
      if (e > n) return;
      push(e, pack(0, 1, 0, 0, 0, retries), n);
      w = e;
      run_at = -1;
      timed_out = 0;
      while (run_at < 0 && !timed_out) begin
        f = -1;
        for (int k = 1; k <= TO; k++) if (lkv(w + k)) begin f = w + k; break; end
        if (f < 0) timed_out = 1;
        else begin
          if (f > n) return;
          j = 1;
          while (j <= ST && lkv(f + j)) j++;
          if (j > ST) run_at = f + ST;
          else w = f + j;
        end
        if (w > n) return;
      end
      if (timed_out) begin
        e = w + TO;
        if (e > n) return;
        if (retries == MAXR) begin
          push(e, pack(1, 1, 0, 0, 1, retries), n);
          return;
        end
        retries++;
        push(e, pack(1, 1, 0, 0, 0, retries), n);
        continue;
      end
      if (run_at > n) return;
      retries = 0;
      push(run_at, pack(0, 0, 1, 0, 0, 0), n);
      g = run_at + 1;
      while (lkv(g)) begin
        g++;
        if (g > n) return;
      end
      push(g, pack(1, 1, 0, 1, 0, 0), n);
      push(g + 1, pack(1, 1, 0, 0, 0, 0), n);
      e = g;
    end
  endfunction

  // Monitor: pops an expected event whenever the DUT output vector changes.
  initial begin
    forever begin
      @(posedge refclk);
      #1;
      if (mon_en) begin
        logic [7:0] cur;
        ev_t x;
        mon_cyc++;
        cur = dut_vec();
        compared++;
        if (sys_rst !== !ready) begin
          mismatched++;
          $display("FAIL invariant cyc=%0d: sys_rst=%b ready=%b, required sys_rst==!ready",
                   mon_cyc, sys_rst, ready);
        end
        if (cur !== prev_v) begin
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_change cyc=%0d: got %02h (was %02h), required no change",
                     mon_cyc, cur, prev_v);
          end else begin
            x = exp_q.pop_front();
            if (x.cyc != mon_cyc || x.v !== cur) begin
              mismatched++;
              $display("FAIL event: got %02h at cycle %0d, required %02h at cycle %0d",
                       cur, mon_cyc, x.v, x.cyc);
            end
          end
          prev_v = cur;
        end
      end
    end
  end

  task automatic check_reset_values(string tag);
    compared++;
    if (dut_vec() !== pack(1, 1, 0, 0, 0, 0)) begin
      mismatched++;
      $display("FAIL %s: got %02h, required %02h", tag, dut_vec(), pack(1, 1, 0, 0, 0, 0));
    end
  endtask

  task automatic run_scenario(string name, int n);
    build_model(n);
    @(negedge refclk);
    pll_locked = L[1];
    rst_n = 1'b1;
    mon_cyc = 0;
    prev_v = pack(1, 1, 0, 0, 0, 0);
    mon_en = 1;
    for (int e = 1; e <= n; e++) begin
      @(posedge refclk);
      #1;
      pll_locked = L[e+1];
    end
    #2;
    mon_en = 0;
    while (exp_q.size() > 0) begin
      ev_t x;
      x = exp_q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL %s missing_event: no change seen, required %02h at cycle %0d", name, x.v, x.cyc);
    end
    compared++;
    if (dut_vec() !== last_exp) begin
      mismatched++;
      $display("FAIL %s final_state: got %02h, required %02h", name, dut_vec(), last_exp);
    end
    rst_n = 1'b0;
    #1;
    check_reset_values({name, " async_reset"});
    pll_locked = 1'b0;
    repeat (3) @(posedge refclk);
  endtask

  task automatic clear_l();
    for (int i = 0; i <= MAXN + 3; i++) L[i] = 1'b0;
  endtask

  task automatic set_l(int a, int b, bit v);
    for (int i = a; i <= b && i <= MAXN + 3; i++) L[i] = v;
  endtask

  initial begin
    repeat (2) @(posedge refclk);
    #3;
    check_reset_values("initial_reset");

    clear_l(); set_l(14, MAXN + 3, 1);
    run_scenario("nominal", 60);

    clear_l(); set_l(14, MAXN + 3, 1); set_l(20, 22, 0);
    run_scenario("stable_glitch", 60);

    clear_l();
    run_scenario("timeout_fail", 140);

    clear_l(); set_l(50, MAXN + 3, 1); set_l(80, 89, 0);
    run_scenario("run_lock_loss", 160);

    clear_l(); set_l(34, MAXN + 3, 1);
    run_scenario("timeout_tie", 80);

    for (int r = 0; r < 6; r++) begin
      int p;
      bit v;
      clear_l();
      p = 1;
      v = 1'b0;
      while (p <= MAXN + 3) begin
        int len;
        len = v ? int'($urandom_range(3, 70)) : int'($urandom_range(1, 45));
        for (int i = 0; i < len && p <= MAXN + 3; i++) begin
          L[p] = v;
          p++;
        end
        v = ~v;
      end
      run_scenario("random", 400);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
